// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit owning the HI/LO register pair
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg_a;
    logic                 neg_b;
    logic                 sgn;
    logic                 is_div;

    logic                 op_signed;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    always_comb begin
        op_signed = ~op[0];
        a_abs     = (op_signed && A[WIDTH-1]) ? -A : A;
        b_abs     = (op_signed && B[WIDTH-1]) ? -B : B;

        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the whole pair right.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : '0)};

        // Divide: remainder in the upper half, dividend/quotient in the lower.
        rem_sh    = acc[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_sh - {1'b0, opb};

        if (is_div) begin
            if (rem_diff[WIDTH])
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end

        prod_fix = (sgn && (neg_a ^ neg_b)) ? -acc : acc;
        quot_fix = (sgn && (neg_a ^ neg_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = (sgn && neg_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            sgn      <= 1'b0;
            is_div   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'b100: hi <= A;
                            3'b101: lo <= A;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                busy <= 1'b1;
                                if (op[1] && (B == '0)) begin
                                    done     <= 1'b1;
                                    div_zero <= 1'b1;
                                    state    <= DONE;
                                end else begin
                                    opa    <= a_abs;
                                    opb    <= b_abs;
                                    acc    <= op[1] ? {{WIDTH{1'b0}}, a_abs}
                                                    : {{WIDTH{1'b0}}, b_abs};
                                    neg_a  <= A[WIDTH-1];
                                    neg_b  <= B[WIDTH-1];
                                    sgn    <= op_signed;
                                    is_div <= op[1];
                                    cnt    <= '0;
                                    state  <= CALC;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit against an arithmetic model
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_dz;

    md_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: MIPS semantics computed with plain 64-bit arithmetic.
    function automatic void model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sx, sy, sq, sr;
        logic [63:0] p, ua, ub, tq, tr;
        sx = longint'($signed(a));
        sy = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        m_dz = 1'b0;
        case (o)
            3'd0: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin
                if (b == 0) m_dz = 1'b1;
                else begin
                    sq = sx / sy; sr = sx % sy;
                    tq = sq; tr = sr;
                    m_lo = tq[31:0]; m_hi = tr[31:0];
                end
            end
            3'd3: begin
                if (b == 0) m_dz = 1'b1;
                else begin m_lo = a / b; m_hi = a % b; end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [2:0] o, input logic [31:0] b);
        if (o >= 3'd4) return 0;
        if (o[1] && b == 0) return 1;
        return 34;
    endfunction

    // Issue one request and observe completion; operands are scrambled right after E0.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic dz_seen,
                         output logic busy_after, output logic done_after);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        dz_seen = 1'b0;
        if (o >= 3'd4) begin
            cyc = 0;
        end else begin
            cyc = 1;
            while (!done && cyc < 60) begin
                @(negedge clk);
                cyc++;
            end
            dz_seen = div_zero;
            @(negedge clk);
        end
        busy_after = busy;
        done_after = done;
    endtask

    task automatic run_and_check(input string name, input logic [2:0] o,
                                 input logic [31:0] a, input logic [31:0] b);
        int   cyc, ecyc;
        logic dz, ba, da;
        model_op(o, a, b);
        ecyc = exp_cycles(o, b);
        do_op(o, a, b, cyc, dz, ba, da);
        checks++;
        if (cyc !== ecyc) begin
            errors++;
            $display("FAIL %s latency op=%0d got %0d want %0d", name, o, cyc, ecyc);
        end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL %s result op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                     name, o, a, b, hi, lo, m_hi, m_lo);
        end
        checks++;
        if (dz !== m_dz || ba !== 1'b0 || da !== 1'b0) begin
            errors++;
            $display("FAIL %s flags op=%0d got dz=%b busy=%b done=%b want dz=%b busy=0 done=0",
                     name, o, dz, ba, da, m_dz);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset got hi=%h lo=%h busy=%b done=%b dz=%b want all zero",
                     hi, lo, busy, done, div_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int   cyc;
        logic dz, ba, da;
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'hFFFFFFFD; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mult_busy got %b want 1", busy);
        end
        cyc = 1;
        while (!done && cyc < 60) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc !== 34 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL mult_neg got cyc=%0d hi=%h lo=%h dz=%b want cyc=34 hi=ffffffff lo=fffffff1 dz=0",
                     cyc, hi, lo, div_zero);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mult_end got busy=%b done=%b want 0 0", busy, done);
        end
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF1;
        dz = 0; ba = 0; da = 0;
    endtask

    task automatic test_multu_divu;
        run_and_check("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++;
            $display("FAIL multu_const got hi=%h lo=%h want fffffffe 00000001", hi, lo);
        end
        run_and_check("divu_100_7", 3'd3, 32'd100, 32'd7);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL divu_const got hi=%h lo=%h want 2 14", hi, lo);
        end
    endtask

    task automatic test_div_signed;
        run_and_check("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_neg_const got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
        end
        run_and_check("div_wrap", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h80000000) begin
            errors++;
            $display("FAIL div_wrap_const got hi=%h lo=%h want 0 80000000", hi, lo);
        end
        run_and_check("div_pos_neg", 3'd2, 32'd7, 32'hFFFFFFFE);
    endtask

    task automatic test_div_zero;
        run_and_check("mthi", 3'd4, 32'h1234, 32'h0);
        run_and_check("mtlo", 3'd5, 32'h5678, 32'h0);
        run_and_check("divu_zero", 3'd3, 32'd5, 32'd0);
        checks++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++;
            $display("FAIL divzero_hold got hi=%h lo=%h want 1234 5678", hi, lo);
        end
        run_and_check("div_zero_s", 3'd2, 32'hFFFF0000, 32'd0);
    endtask

    task automatic test_busy_ignore;
        int cyc;
        model_op(3'd0, 32'h12345678, 32'hF0F0F0F1);
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'h12345678; B = 32'hF0F0F0F1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            if (cyc == 10) begin start = 1'b1; op = 3'd4; A = 32'hAAAA; end
            else if (cyc == 11) begin start = 1'b1; op = 3'd5; A = 32'h5555; end
            else begin start = 1'b0; A = $urandom; B = $urandom; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc !== 34 || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL busy_ignore got cyc=%0d hi=%h lo=%h want cyc=34 hi=%h lo=%h",
                     cyc, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got hi=%h lo=%h busy=%b done=%b want 0 0 0 0", hi, lo, busy, done);
        end
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet got %0d active cycles want 0", seen);
        end
        run_and_check("after_reset", 3'd2, 32'd1000, 32'd3);
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: a = 32'h80000000;
                default: ;
            endcase
            run_and_check("random", o, a, b);
        end
    endtask

    task automatic test_back_to_back;
        run_and_check("b2b_mult", 3'd0, 32'h7FFFFFFF, 32'h80000000);
        run_and_check("b2b_divu", 3'd3, 32'hFFFFFFFF, 32'd1);
        run_and_check("b2b_mthi", 3'd4, 32'hDEADBEEF, 32'd0);
        run_and_check("b2b_nop", 3'd7, 32'h11111111, 32'd0);
        run_and_check("b2b_multu", 3'd1, 32'h0, 32'hFFFFFFFF);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_multu_divu();
        test_div_signed();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
